// File: rtl/game_pkg.sv
// Shared constants for the maze game flow: mode encodings, PS/2 key codes,
// and direction bit positions used by the movement logic.
package game_pkg;

    localparam logic [2:0] MODE_TITLE   = 3'd0;
    localparam logic [2:0] MODE_LOAD    = 3'd1;
    localparam logic [2:0] MODE_PLAY    = 3'd2;
    localparam logic [2:0] MODE_SUCCESS = 3'd3;
    localparam logic [2:0] MODE_FAIL    = 3'd4;
    localparam logic [2:0] MODE_STAFF   = 3'd5;

    localparam logic [8:0] KEY_RSHIFT = 9'h059;
    localparam logic [8:0] KEY_W      = 9'h01D;
    localparam logic [8:0] KEY_A      = 9'h01C;
    localparam logic [8:0] KEY_S      = 9'h01B;
    localparam logic [8:0] KEY_D      = 9'h023;
    localparam logic [8:0] KEY_N      = 9'h031;
    localparam logic [8:0] KEY_B      = 9'h032;
    localparam logic [8:0] KEY_R      = 9'h02D;

    // Digits 1..9 in order; index k selects stage k.
    localparam logic [8:0] DIGIT_CODES [9] = '{
        9'h069, 9'h072, 9'h07A, 9'h06B, 9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D
    };

    // Bit positions in the 4-bit direction vectors.
    localparam int DIR_W = 3;
    localparam int DIR_A = 2;
    localparam int DIR_S = 1;
    localparam int DIR_D = 0;

endpackage

// File: rtl/move_repeat.sv
// Turns direction presses and held keys into one-hot step pulses:
// a press steps at once, a held key steps again every REPEAT cycles.
module move_repeat
    import game_pkg::*;
#(
    parameter int unsigned REPEAT = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] held,
    input  logic [3:0] press,
    output logic [3:0] step
);

    localparam int CW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    logic [CW-1:0] cnt;
    logic [3:0]    held_pick;
    logic          wrap;

    assign wrap = (cnt == CW'(REPEAT - 1));

    always_comb begin
        held_pick = 4'b0000;
        if (held[DIR_W])      held_pick[DIR_W] = 1'b1;
        else if (held[DIR_A]) held_pick[DIR_A] = 1'b1;
        else if (held[DIR_S]) held_pick[DIR_S] = 1'b1;
        else if (held[DIR_D]) held_pick[DIR_D] = 1'b1;
    end

    always_comb begin
        step = 4'b0000;
        if (enable) begin
            if (press != 4'b0000) step = press;
            else if (wrap)        step = held_pick;
        end
    end

    // Any press, release of all keys, or leaving PLAY restarts the interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!enable || press != 4'b0000 || held == 4'b0000 || wrap)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/stage_controller.sv
// Title/play/result flow for the maze game: owns stage index, player and
// goal coordinates, step movement with hold-to-repeat, and the stage timer.
module stage_controller
    import game_pkg::*;
#(
    parameter int                    NUM_STAGES = 3,
    parameter int                    COORD_W    = 9,
    parameter int                    X_MAX      = 304,
    parameter int                    Y_MAX      = 224,
    parameter int                    STEP       = 16,
    parameter int unsigned           REPEAT     = 12_500_000,
    parameter int unsigned           TIME_LIMIT = 1_000_000_000,
    parameter logic [NUM_STAGES-1:0] TIMED      = 'b100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [8:0]         last_change,
    input  logic [511:0]       key_down,
    input  logic [COORD_W-1:0] spawn_x,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic [COORD_W-1:0] goal_x,
    input  logic [COORD_W-1:0] goal_y,
    output logic [2:0]         mode,
    output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] stage,
    output logic [COORD_W-1:0] player_x,
    output logic [COORD_W-1:0] player_y,
    output logic [COORD_W-1:0] key_x,
    output logic [COORD_W-1:0] key_y,
    output logic [31:0]        time_left
);

    localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [COORD_W:0] STEP_W = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0] XMAX_W = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0] YMAX_W = (COORD_W+1)'(Y_MAX);

    logic          press_evt, digit_hit, at_goal, timed, timeout;
    logic [SW-1:0] digit_stage, stage_d;
    logic [2:0]    mode_d;
    logic [3:0]    held, press_dir, step;
    logic [COORD_W:0]   px_w, py_w, up_x, up_y;
    logic [COORD_W-1:0] x_n, y_n;

    assign press_evt = key_valid && key_down[last_change];
    assign held      = {key_down[KEY_W], key_down[KEY_A], key_down[KEY_S], key_down[KEY_D]};
    assign press_dir = press_evt ? {last_change == KEY_W, last_change == KEY_A,
                                    last_change == KEY_S, last_change == KEY_D} : 4'b0000;
    assign at_goal   = (player_x == key_x) && (player_y == key_y);
    assign timed     = TIMED[stage];
    assign timeout   = timed && (time_left <= 32'd1);

    move_repeat #(.REPEAT(REPEAT)) u_move_repeat (
        .clk    (clk),
        .rst    (rst),
        .enable (mode == MODE_PLAY),
        .held   (held),
        .press  (press_dir),
        .step   (step)
    );

    always_comb begin
        digit_hit   = 1'b0;
        digit_stage = '0;
        for (int k = 0; k < 9; k++) begin
            if (k < NUM_STAGES && last_change == DIGIT_CODES[k]) begin
                digit_hit   = 1'b1;
                digit_stage = SW'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mode <= MODE_TITLE;
        else     mode <= mode_d;
    end

    // Goal beats timeout, and both beat R/B pressed on the same cycle.
    always_comb begin
        mode_d  = mode;
        stage_d = stage;
        case (mode)
            MODE_TITLE: if (press_evt) begin
                if (last_change == KEY_RSHIFT) begin
                    stage_d = '0;
                    mode_d  = MODE_LOAD;
                end else if (digit_hit) begin
                    stage_d = digit_stage;
                    mode_d  = MODE_LOAD;
                end
            end
            MODE_LOAD: mode_d = MODE_PLAY;
            MODE_PLAY: begin
                if (at_goal)                                mode_d = MODE_SUCCESS;
                else if (timeout)                           mode_d = MODE_FAIL;
                else if (press_evt && last_change == KEY_R) mode_d = MODE_LOAD;
                else if (press_evt && last_change == KEY_B) mode_d = MODE_TITLE;
            end
            MODE_SUCCESS: if (press_evt) begin
                if (last_change == KEY_N) begin
                    if (stage == SW'(NUM_STAGES - 1)) begin
                        mode_d = MODE_STAFF;
                    end else begin
                        stage_d = stage + SW'(1);
                        mode_d  = MODE_LOAD;
                    end
                end
                else if (last_change == KEY_R) mode_d = MODE_LOAD;
                else if (last_change == KEY_B) mode_d = MODE_TITLE;
            end
            MODE_FAIL: if (press_evt) begin
                if (last_change == KEY_R)      mode_d = MODE_LOAD;
                else if (last_change == KEY_B) mode_d = MODE_TITLE;
            end
            MODE_STAFF: if (press_evt && (last_change == KEY_N || last_change == KEY_B)) begin
                stage_d = '0;
                mode_d  = MODE_TITLE;
            end
            default: mode_d = MODE_TITLE;
        endcase
    end

    assign px_w = {1'b0, player_x};
    assign py_w = {1'b0, player_y};

    always_comb begin
        x_n  = player_x;
        y_n  = player_y;
        up_x = px_w + STEP_W;
        up_y = py_w + STEP_W;
        if (step[DIR_W])      y_n = (py_w < STEP_W) ? '0 : COORD_W'(py_w - STEP_W);
        else if (step[DIR_S]) y_n = (up_y > YMAX_W) ? COORD_W'(YMAX_W) : COORD_W'(up_y);
        else if (step[DIR_A]) x_n = (px_w < STEP_W) ? '0 : COORD_W'(px_w - STEP_W);
        else if (step[DIR_D]) x_n = (up_x > XMAX_W) ? COORD_W'(XMAX_W) : COORD_W'(up_x);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage     <= '0;
            player_x  <= '0;
            player_y  <= '0;
            key_x     <= '0;
            key_y     <= '0;
            time_left <= TIME_LIMIT;
        end else begin
            stage <= stage_d;
            if (mode == MODE_LOAD) begin
                player_x  <= spawn_x;
                player_y  <= spawn_y;
                key_x     <= goal_x;
                key_y     <= goal_y;
                time_left <= TIME_LIMIT;
            end else if (mode == MODE_PLAY) begin
                player_x <= x_n;
                player_y <= y_n;
                if (timed && time_left != 32'd0) time_left <= time_left - 32'd1;
            end
        end
    end

endmodule

// File: doc/stage_controller.md
# stage_controller

Parametrised game-flow controller for the maze game. It sits between `KeyboardDecoder` and the VGA renderer, and runs an N-stage title/play/result state machine. It owns the player and key (goal) coordinates, with clamped step movement, hold-to-repeat, and a per-stage optional time limit. Stage layouts come from an external stage ROM, addressed by the `stage` output.

## Interface
Parameters:
- `NUM_STAGES`, default 3: number of playable stages, 1..9.
- `COORD_W`, default 9: coordinate width.
- `X_MAX`, default 304: largest legal `player_x`.
- `Y_MAX`, default 224: largest legal `player_y`.
- `STEP`, default 16: pixels moved per step.
- `REPEAT`, default 12_500_000: cycles between auto-repeat steps while a move key is held.
- `TIME_LIMIT`, default 1_000_000_000: cycles allowed per timed stage.
- `TIMED`, default `'b100`: NUM_STAGES-bit mask; bit i set means stage i is timed.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `key_valid` in 1: one-cycle pulse from `KeyboardDecoder`.
- `last_change` in 9: code of the last key that changed.
- `key_down` in 512: held-key vector.
- `spawn_x`, `spawn_y` in COORD_W: ROM start position for `stage`.
- `goal_x`, `goal_y` in COORD_W: ROM key position for `stage`.
- `mode` out 3: TITLE=0, LOAD=1, PLAY=2, SUCCESS=3, FAIL=4, STAFF=5.
- `stage` out `$clog2(NUM_STAGES)` (min 1): current stage index.
- `player_x`, `player_y` out COORD_W: player position.
- `key_x`, `key_y` out COORD_W: goal position.
- `time_left` out 32: remaining cycles. Holds at TIME_LIMIT when the stage is untimed.

## Operation
- Reset values:
  - `mode`=TITLE, `stage`=0.
  - `player_x`, `player_y`, `key_x`, `key_y` all 0.
  - `time_left`=TIME_LIMIT.
  - Repeat counter 0.
- A key press is an event where `key_valid`=1 and `key_down[last_change]`=1. Break codes are ignored.
- Key codes: right shift 0x59, digits 1–9 (0x69, 0x72, 0x7A, 0x6B, 0x73, 0x74, 0x6C, 0x75, 0x7D), W 0x1D, A 0x1C, S 0x1B, D 0x23, N 0x31, B 0x32, R 0x2D.
- TITLE:
  - Right shift: `stage`←0, go to LOAD.
  - Digit k with k ≤ NUM_STAGES: `stage`←k−1, go to LOAD.
  - Digit k with k > NUM_STAGES: ignored.
- LOAD:
  - Lasts exactly one cycle.
  - Latches spawn → player and goal → key.
  - Sets `time_left`←TIME_LIMIT and clears the repeat counter.
  - Then goes to PLAY.
- PLAY:
  - R: go to LOAD (same stage).
  - B: go to TITLE.
  - W/A/S/D press: apply one step immediately and clear the repeat counter.
  - While that direction's key stays held, apply another step every REPEAT cycles.
  - Held-direction priority: W > A > S > D. Only one step is applied per cycle.
  - Clamping is saturating:
    - W: y = y<STEP ? 0 : y−STEP.
    - S: y = min(y+STEP, Y_MAX).
    - A/D follow the same rules on x, with X_MAX as the upper bound.
  - Arithmetic uses COORD_W+1 bits before clamping.
  - Goal reached: if the registered player position equals the key position, go to SUCCESS on the next cycle.
  - Timeout: if TIMED[stage] is set, `time_left` decrements each cycle. When it reaches 0, go to FAIL.
  - If goal-reached and timeout happen on the same cycle, SUCCESS wins.
- SUCCESS:
  - N with stage < NUM_STAGES−1: `stage`+1, go to LOAD.
  - N on the last stage: go to STAFF.
  - R: go to LOAD.
  - B: go to TITLE.
- FAIL:
  - R: go to LOAD.
  - B: go to TITLE.
- STAFF:
  - N or B: go to TITLE, `stage`←0.
- Any key not listed for the current mode is ignored. All outputs hold outside PLAY/LOAD.

## Timing
- All outputs are registered.
- A press event at cycle t changes `mode` or position at t+1.
- LOAD occupies t+1. Positions are valid and `mode`=PLAY at t+2.
- Goal detection is registered: the move lands at t+1, `mode`=SUCCESS at t+2.
- Hold-repeat: the first step happens on the press; later steps at press+REPEAT, press+2·REPEAT, and so on. Releasing the key stops repeating.
- `rst` mid-operation clears everything immediately, regardless of `clk`.

## Structure
- Package `game_pkg` holds:
  - Mode localparams.
  - The key-code constants listed above.
  - The digit-code array.
- Sub-module `move_repeat`:
  - Inputs: held-direction vector and press pulse.
  - Owns the REPEAT counter.
  - Outputs a one-hot step pulse.
- The stage ROM is external and not part of this block.

## Test plan
- Reset, then press right shift with spawn=(16,16), goal=(48,16). Expect LOAD for 1 cycle, then PLAY with `stage`=0 and player=(16,16).
- Two D presses. Expect player x 16→32→48, then `mode`=SUCCESS 1 cycle later. N then gives `stage`=1 via LOAD.
- Player at (0,224): press W-less A, then S. Expect x clamped to 0 and y held at 224 (no wrap).
- Hold W with REPEAT=4. Expect steps at press and at +4, +8, +12 cycles. Release stops steps. Hold W+D: only W steps.
- Digit 3 with TIMED=`'b100` and TIME_LIMIT=10. Expect FAIL 10 cycles after PLAY. R returns to LOAD with `time_left`=10. Goal reached on the timeout cycle gives SUCCESS.
- From SUCCESS on stage 2, press N. Expect STAFF. B gives TITLE with `stage`=0. Assert `rst` during PLAY: all outputs return to reset values immediately.
